// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS control unit.
//   - state encoding constants (FETCH = 0 ... JUMP = 11)
//   - opcode and funct field constants
//   - 3-bit ALU control codes and the 2-bit alu_op encoding
//   - ctrl_t: the bundle of Moore outputs produced per state
// Optional feature macro: MC_CTRL_BNE_EN (adds bne handling in mc_controller).
package mc_pkg;

  // FSM state encoding
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  // instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // instruction[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation-select codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Request from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  // Moore outputs of one state
  typedef struct packed {
    logic      pc_write;
    logic      branch;
    logic      iord;
    logic      mem_write;
    logic      ir_write;
    logic      reg_dst;
    logic      mem_to_reg;
    logic      reg_write;
    logic      alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    alu_op_e   alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// alu_decoder: combinational map from alu_op + funct to the ALU control code.
//   alu_op      in  request from the FSM (ADD, SUB or FUNCT)
//   funct       in  instruction[5:0]
//   alu_control out 3-bit ALU code; always one of AND/OR/ADD/SUB/SLT
module alu_decoder
  import mc_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        // Unknown funct falls back to ADD so the ALU never sees an undefined code
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM for the multicycle MIPS datapath.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   op, funct      instruction fields from the instruction register
//   zero           ALU zero flag, used only for the branch decision
//   pc_en .. pc_src  datapath enables and mux selects
//   alu_control    ALU operation code (via alu_decoder)
//   state_o        current FSM state
// Optional feature: define MC_CTRL_BNE_EN to decode bne (op 000101) into
// the BRANCH state with inverted zero polarity.
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_control,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_t              ctrl;
  logic               br_cond;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

`ifdef MC_CTRL_BNE_EN
  // Branch polarity: captured while leaving DECODE, held through BRANCH
  logic bne_q, bne_d;

  always_comb begin
    bne_d = bne_q;
    if (state_q == DECODE) bne_d = (op == OP_BNE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bne_q <= 1'b0;
    else        bne_q <= bne_d;
  end

  assign br_cond = bne_q ? ~zero : zero;
`else
  assign br_cond = zero;
`endif

  // Next-state logic
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = BRANCH;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;  // unknown opcode behaves as a nop
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      state_d = MEMRD;
        else if (op == OP_SW) state_d = MEMWR;
        else                  state_d = FETCH;
      end
      MEMRD:   state_d = MEMWB;
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = FETCH;
      EXEC:    state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode. While rst_n is low the idle defaults are held, which also
  // keeps any write from firing in the reset cycle of an abandoned instruction.
  always_comb begin
    ctrl.pc_write   = 1'b0;
    ctrl.branch     = 1'b0;
    ctrl.iord       = 1'b0;
    ctrl.mem_write  = 1'b0;
    ctrl.ir_write   = 1'b0;
    ctrl.reg_dst    = 1'b0;
    ctrl.mem_to_reg = 1'b0;
    ctrl.reg_write  = 1'b0;
    ctrl.alu_src_a  = 1'b0;
    ctrl.alu_src_b  = 2'b00;
    ctrl.pc_src     = 2'b00;
    ctrl.alu_op     = ALU_OP_ADD;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          ctrl.ir_write  = 1'b1;
          ctrl.alu_src_b = 2'b01;
          ctrl.pc_write  = 1'b1;
        end
        DECODE: begin
          ctrl.alu_src_b = 2'b11;  // branch target into ALUOut
        end
        MEMADR, ADDIEX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = 2'b10;
        end
        MEMRD: begin
          ctrl.iord = 1'b1;
        end
        MEMWB: begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        MEMWR: begin
          ctrl.iord      = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_op    = ALU_OP_FUNCT;
        end
        ALUWB: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_op    = ALU_OP_SUB;
          ctrl.pc_src    = 2'b01;
          ctrl.branch    = 1'b1;
        end
        ADDIWB: begin
          ctrl.reg_write = 1'b1;
        end
        JUMP: begin
          ctrl.pc_src   = 2'b10;
          ctrl.pc_write = 1'b1;
        end
        default: ;  // illegal encodings keep every enable low
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

  assign pc_en      = ctrl.pc_write | (ctrl.branch & br_cond);
  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign state_o    = state_q;

endmodule
